// File: rtl/regfile_pkg.sv
// Shared register-file widths and the writeback queue entry type.
package regfile_pkg;

    localparam int ADDR_WIDTH = 5;
    localparam int REG_DATA_W = 32;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_bypass_lookup.sv
// Youngest-match search across the output register and the pending queue entries.
module wb_bypass_lookup
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wb_entry_t [DEPTH-1:0]         entries_i,
    input  logic      [DEPTH-1:0]         valid_i,
    input  logic      [$clog2(DEPTH)-1:0] head_i,
    input  logic                          out_valid_i,
    input  wb_entry_t                     out_entry_i,
    input  logic      [ADDR_WIDTH-1:0]    raddr_i,
    output logic                          hit_o,
    output logic      [REG_DATA_W-1:0]    data_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest so the last match found wins.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        if (raddr_i != '0) begin
            if (out_valid_i && (out_entry_i.addr == raddr_i)) begin
                hit_o  = 1'b1;
                data_o = out_entry_i.data;
            end
            for (int k = 0; k < DEPTH; k++) begin
                idx = head_i + PTR_W'(k);
                if (valid_i[idx] && (entries_i[idx].addr == raddr_i)) begin
                    hit_o  = 1'b1;
                    data_o = entries_i[idx].data;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_wb_buffer.sv
// In-order writeback queue (LSU before ALU) draining one regfile write per cycle.
// Define WB_BYPASS_EN to build the read-port bypass; otherwise hits/data are tied to 0.
module regfile_wb_buffer
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      ares,
    input  logic                      alu_valid,
    output logic                      alu_ready,
    input  logic [ADDR_WIDTH-1:0]     alu_addr,
    input  logic [REG_DATA_W-1:0]     alu_data,
    input  logic                      lsu_valid,
    output logic                      lsu_ready,
    input  logic [ADDR_WIDTH-1:0]     lsu_addr,
    input  logic [REG_DATA_W-1:0]     lsu_data,
    input  logic                      rf_stall,
    output logic                      wen,
    output logic [ADDR_WIDTH-1:0]     waddr,
    output logic [REG_DATA_W-1:0]     wdata,
    input  logic [ADDR_WIDTH-1:0]     raddr1,
    input  logic [ADDR_WIDTH-1:0]     raddr2,
    output logic                      byp_hit1,
    output logic [REG_DATA_W-1:0]     byp_data1,
    output logic                      byp_hit2,
    output logic [REG_DATA_W-1:0]     byp_data2,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t [DEPTH-1:0] mem_q;
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [PTR_W-1:0]      alu_slot;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [CNT_W-1:0]      free;
    logic                  wen_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [REG_DATA_W-1:0] wdata_q;
    logic                  lsu_rdy, alu_rdy;
    logic                  lsu_push, alu_push, pop;

    // Free slots come from the registered count; a same-cycle pop is not credited.
    always_comb begin
        free     = CNT_W'(DEPTH) - count_q;
        lsu_rdy  = !ares && (free >= CNT_W'(1));
        alu_rdy  = !ares && ((free >= CNT_W'(2)) || ((free == CNT_W'(1)) && !lsu_valid));
        lsu_push = lsu_valid && lsu_rdy && (lsu_addr != '0);
        alu_push = alu_valid && alu_rdy && (alu_addr != '0);
        pop      = (count_q != '0) && !rf_stall;
        alu_slot = tail_q + PTR_W'(lsu_push);
        head_d   = head_q + PTR_W'(pop);
        tail_d   = tail_q + PTR_W'(lsu_push) + PTR_W'(alu_push);
        count_d  = count_q + CNT_W'(lsu_push) + CNT_W'(alu_push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (ares) begin
            mem_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            if (lsu_push) mem_q[tail_q]   <= '{addr: lsu_addr, data: lsu_data};
            if (alu_push) mem_q[alu_slot] <= '{addr: alu_addr, data: alu_data};
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            wen_q   <= pop;
            if (pop) begin
                waddr_q <= mem_q[head_q].addr;
                wdata_q <= mem_q[head_q].data;
            end
        end
    end

    assign lsu_ready = lsu_rdy;
    assign alu_ready = alu_rdy;
    assign wen       = wen_q;
    assign waddr     = waddr_q;
    assign wdata     = wdata_q;
    assign count     = count_q;

`ifdef WB_BYPASS_EN
    logic [DEPTH-1:0] valid_mask;
    logic [PTR_W-1:0] age;
    wb_entry_t        out_entry;

    always_comb begin
        valid_mask = '0;
        age        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            age           = PTR_W'(i) - head_q;
            valid_mask[i] = (CNT_W'(age) < count_q);
        end
    end

    assign out_entry = '{addr: waddr_q, data: wdata_q};

    wb_bypass_lookup #(.DEPTH(DEPTH)) u_byp1 (
        .entries_i   (mem_q),
        .valid_i     (valid_mask),
        .head_i      (head_q),
        .out_valid_i (wen_q),
        .out_entry_i (out_entry),
        .raddr_i     (raddr1),
        .hit_o       (byp_hit1),
        .data_o      (byp_data1)
    );

    wb_bypass_lookup #(.DEPTH(DEPTH)) u_byp2 (
        .entries_i   (mem_q),
        .valid_i     (valid_mask),
        .head_i      (head_q),
        .out_valid_i (wen_q),
        .out_entry_i (out_entry),
        .raddr_i     (raddr2),
        .hit_o       (byp_hit2),
        .data_o      (byp_data2)
    );
`else
    logic unused_byp;
    assign unused_byp = ^{raddr1, raddr2};
    assign byp_hit1   = 1'b0;
    assign byp_data1  = '0;
    assign byp_hit2   = 1'b0;
    assign byp_data2  = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_buffer.sv
// Bench for regfile_wb_buffer: vector table plus corner sequences, checked against a queue model.
// Bypass expectations follow WB_BYPASS_EN as compiled.
module tb_regfile_wb_buffer;
    import regfile_pkg::*;

    localparam int DEPTH = 4;

    logic                  clk = 1'b0;
    logic                  ares;
    logic                  alu_valid, alu_ready, lsu_valid, lsu_ready;
    logic [ADDR_WIDTH-1:0] alu_addr, lsu_addr, waddr, raddr1, raddr2;
    logic [REG_DATA_W-1:0] alu_data, lsu_data, wdata, byp_data1, byp_data2;
    logic                  rf_stall, wen, byp_hit1, byp_hit2;
    logic [$clog2(DEPTH):0] count;

    regfile_wb_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .ares(ares),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_addr(lsu_addr), .lsu_data(lsu_data),
        .rf_stall(rf_stall), .wen(wen), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2),
        .byp_hit1(byp_hit1), .byp_data1(byp_data1), .byp_hit2(byp_hit2), .byp_data2(byp_data2),
        .count(count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model state: pending entries, output register, expected-write scoreboard.
    wb_entry_t             mdl_q[$];
    wb_entry_t             sb_q[$];
    logic                  m_wen;
    logic [ADDR_WIDTH-1:0] m_waddr;
    logic [REG_DATA_W-1:0] m_wdata;

    typedef struct {
        logic                  stall;
        logic                  lv;
        logic [ADDR_WIDTH-1:0] la;
        logic                  av;
        logic [ADDR_WIDTH-1:0] aa;
        logic                  exp_lr;
        logic                  exp_ar;
        int                    exp_cnt;
    } vec_t;

    vec_t vecs[10];

    function automatic vec_t mk(logic st, logic lv, int la, logic av, int aa,
                                logic lr, logic ar, int cnt);
        vec_t v;
        v.stall = st; v.lv = lv; v.la = ADDR_WIDTH'(la); v.av = av; v.aa = ADDR_WIDTH'(aa);
        v.exp_lr = lr; v.exp_ar = ar; v.exp_cnt = cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic lv, input int la, input logic [31:0] ld,
                         input logic av, input int aa, input logic [31:0] ad);
        lsu_valid = lv; lsu_addr = ADDR_WIDTH'(la); lsu_data = ld;
        alu_valid = av; alu_addr = ADDR_WIDTH'(aa); alu_data = ad;
    endtask

    function automatic void byp_model(input logic [ADDR_WIDTH-1:0] ra,
                                      output logic hit, output logic [REG_DATA_W-1:0] d);
        hit = 1'b0;
        d   = '0;
`ifdef WB_BYPASS_EN
        if (ra != '0) begin
            if (m_wen && (m_waddr == ra)) begin
                hit = 1'b1;
                d   = m_wdata;
            end
            foreach (mdl_q[i]) begin
                if (mdl_q[i].addr == ra) begin
                    hit = 1'b1;
                    d   = mdl_q[i].data;
                end
            end
        end
`endif
    endfunction

    // One clock of stimulus: check combinational outputs, advance model, check registered outputs.
    task automatic cycle();
        int        free;
        logic      m_lr, m_ar, la, aa, h;
        logic [31:0] d;
        wb_entry_t e;
        #1;
        free = DEPTH - mdl_q.size();
        m_lr = !ares && (free >= 1);
        m_ar = !ares && ((free >= 2) || ((free == 1) && !lsu_valid));
        check("lsu_ready", lsu_ready, m_lr);
        check("alu_ready", alu_ready, m_ar);
        check("count", count, mdl_q.size());
        byp_model(raddr1, h, d);
        check("byp1", {byp_hit1, byp_data1}, {h, d});
        byp_model(raddr2, h, d);
        check("byp2", {byp_hit2, byp_data2}, {h, d});
        la = lsu_valid && m_lr && (lsu_addr != '0);
        aa = alu_valid && m_ar && (alu_addr != '0);
        if (la) sb_q.push_back('{addr: lsu_addr, data: lsu_data});
        if (aa) sb_q.push_back('{addr: alu_addr, data: alu_data});
        @(posedge clk);
        if (ares) begin
            mdl_q.delete();
            sb_q.delete();
            m_wen = 1'b0; m_waddr = '0; m_wdata = '0;
        end else begin
            m_wen = (mdl_q.size() > 0) && !rf_stall;
            if (m_wen) begin
                e = mdl_q.pop_front();
                m_waddr = e.addr;
                m_wdata = e.data;
            end
            if (la) mdl_q.push_back('{addr: lsu_addr, data: lsu_data});
            if (aa) mdl_q.push_back('{addr: alu_addr, data: alu_data});
        end
        #1;
        check("wen", wen, m_wen);
        if (wen === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_spurious: got write r%0d=%0h expected no write", waddr, wdata);
            end else begin
                e = sb_q.pop_front();
                check("sb_write", {waddr, wdata}, e);
            end
        end
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        ares = 1'b1; rf_stall = 1'b0; raddr1 = '0; raddr2 = '0;
        drive(0, 0, 0, 0, 0, 0);
        m_wen = 1'b0; m_waddr = '0; m_wdata = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_count", count, 0);
        check("rst_wen", wen, 0);
        check("rst_waddr", waddr, 0);
        check("rst_wdata", wdata, 0);
        check("rst_lsu_ready", lsu_ready, 0);
        check("rst_alu_ready", alu_ready, 0);
        ares = 1'b0;
        cycle();

        // Table: fill with stall, then drain with an x0 write and a push-with-pop.
        vecs[0] = mk(1, 1, 1, 1, 2, 1, 1, 0);
        vecs[1] = mk(1, 1, 3, 0, 0, 1, 1, 2);
        vecs[2] = mk(1, 1, 4, 1, 5, 1, 0, 3);
        vecs[3] = mk(1, 1, 6, 1, 7, 0, 0, 4);
        vecs[4] = mk(0, 0, 0, 0, 0, 0, 0, 4);
        vecs[5] = mk(0, 0, 0, 1, 0, 1, 1, 3);
        vecs[6] = mk(0, 0, 0, 1, 9, 1, 1, 2);
        vecs[7] = mk(0, 0, 0, 0, 0, 1, 1, 2);
        vecs[8] = mk(0, 0, 0, 0, 0, 1, 1, 1);
        vecs[9] = mk(0, 0, 0, 0, 0, 1, 1, 0);
        raddr1 = 5'd2; raddr2 = 5'd9;
        for (int i = 0; i < 10; i++) begin
            rf_stall = vecs[i].stall;
            drive(vecs[i].lv, int'(vecs[i].la), 32'h1000 + 32'(vecs[i].la),
                  vecs[i].av, int'(vecs[i].aa), 32'h2000 + 32'(vecs[i].aa));
            #1;
            check("vec_lsu_ready", lsu_ready, vecs[i].exp_lr);
            check("vec_alu_ready", alu_ready, vecs[i].exp_ar);
            check("vec_count", count, vecs[i].exp_cnt);
            cycle();
        end
        idle(2);

        // Single ALU write: visible exactly one edge after acceptance, for one cycle.
        drive(0, 0, 0, 1, 5, 32'hDEADBEEF);
        cycle();
        check("t1_wen_early", wen, 0);
        drive(0, 0, 0, 0, 0, 0);
        cycle();
        check("t1_wen", wen, 1);
        check("t1_waddr", waddr, 5);
        check("t1_wdata", wdata, 32'hDEADBEEF);
        cycle();
        check("t1_wen_once", wen, 0);

        // Fill under stall, then four back-to-back writes.
        rf_stall = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(1, i, 32'h4000 + 32'(i), 0, 0, 0);
            cycle();
        end
        drive(1, 6, 32'h6, 1, 7, 32'h7);
        #1;
        check("t2_full_count", count, 4);
        check("t2_full_lsu_ready", lsu_ready, 0);
        check("t2_full_alu_ready", alu_ready, 0);
        drive(0, 0, 0, 0, 0, 0);
        rf_stall = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cycle();
            check("t2_wen", wen, 1);
            check("t2_waddr", waddr, i);
        end
        check("t2_count_empty", count, 0);
        idle(1);

        // One free slot with both producers valid: LSU wins.
        rf_stall = 1'b1;
        for (int i = 10; i <= 12; i++) begin
            drive(1, i, 32'h5000 + 32'(i), 0, 0, 0);
            cycle();
        end
        drive(1, 8, 32'hA, 1, 9, 32'hB);
        #1;
        check("t3_lsu_ready", lsu_ready, 1);
        check("t3_alu_ready", alu_ready, 0);
        cycle();
        drive(0, 0, 0, 1, 9, 32'hB);
        rf_stall = 1'b0;
        #1;
        check("t3_alu_ready_full", alu_ready, 0);
        cycle();
        #1;
        check("t3_alu_ready_after_pop", alu_ready, 1);
        cycle();
        idle(6);

        // x0 write completes the handshake but never reaches the regfile.
        drive(0, 0, 0, 1, 0, 32'h1234);
        #1;
        check("t4_alu_ready", alu_ready, 1);
        cycle();
        check("t4_count", count, 0);
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("t4_no_wen", wen, 0);
        end

        // Two pending writes to r7: the younger one is bypassed.
        rf_stall = 1'b1;
        drive(1, 7, 32'h11, 0, 0, 0);
        cycle();
        drive(1, 7, 32'h22, 0, 0, 0);
        cycle();
        drive(0, 0, 0, 0, 0, 0);
        raddr1 = 5'd7; raddr2 = 5'd3;
        #1;
`ifdef WB_BYPASS_EN
        check("t5_hit1", byp_hit1, 1);
        check("t5_data1", byp_data1, 32'h22);
`else
        check("t5_hit1", byp_hit1, 0);
        check("t5_data1", byp_data1, 0);
`endif
        check("t5_hit2", byp_hit2, 0);
        cycle();
        rf_stall = 1'b0;
        idle(4);

        // Reset with three queued entries discards them all.
        rf_stall = 1'b1;
        for (int i = 20; i <= 22; i++) begin
            drive(1, i, 32'h7000 + 32'(i), 0, 0, 0);
            cycle();
        end
        ares = 1'b1;
        drive(1, 23, 32'h23, 1, 24, 32'h24);
        #1;
        check("t6_rst_lsu_ready", lsu_ready, 0);
        check("t6_rst_alu_ready", alu_ready, 0);
        cycle();
        check("t6_rst_count", count, 0);
        check("t6_rst_wen", wen, 0);
        ares = 1'b0;
        rf_stall = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("t6_no_wen", wen, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
